truth_table_checker: RTL and testbench

//  Self-checking stimulus/response engine for a 4-input, 1-output combinational block.

---
 rtl/truth_table_checker.sv | 152 +++++++++++++++
 tb/tb_truth_table_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker
// Stimulus/response engine for a 4-input, 1-output combinational block.
// Sweeps {A,B,C,D} from 0000 to 1111, holds each vector for SETTLE cycles,
// then compares the block's Y against the expected truth table EXPECT.
// It reports the mismatch count, the first failing vector and pass/fail.
`timescale 1ns/1ps
module truth_table_checker #(
  parameter logic [15:0] EXPECT = 16'h0000,
  parameter int          SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       first_err_vld,
  output logic [3:0] first_err_idx,
  output logic       mism
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CMP,
    ST_DONE
  } state_t;

  // Last value of the settle counter before the compare cycle. With SETTLE=0
  // the DRIVE state is never entered, so the value is irrelevant.
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam bit         SKIP_DRIVE  = (SETTLE == 0);
  // State that follows a start or a completed compare.
  localparam state_t     HOLD_STATE  = SKIP_DRIVE ? ST_CMP : ST_DRIVE;

  state_t     state_reg;
  logic [3:0] idx_reg;
  logic [3:0] settle_cnt_reg;

  logic       mismatch;
  logic [4:0] err_next;

  // The stimulus is the vector index register, so A..D are registered outputs.
  // A is the MSB of the index and D is the LSB.
  assign A = idx_reg[3];
  assign B = idx_reg[2];
  assign C = idx_reg[1];
  assign D = idx_reg[0];

  // Y is sampled at the closing edge of the compare cycle, when the vector has
  // been stable for SETTLE+1 cycles.
  assign mismatch = (Y != EXPECT[idx_reg]);
  assign err_next = err_count + 5'(mismatch);

  // Control FSM. All status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= 4'd0;
      settle_cnt_reg <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 5'd0;
      first_err_vld  <= 1'b0;
      first_err_idx  <= 4'd0;
      mism           <= 1'b0;
    end else begin
      // The mismatch strobe lasts exactly one cycle after a failing compare.
      mism <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // start re-arms from either resting state. abort is ignored here,
          // so start wins when both are high.
          if (start) begin
            err_count      <= 5'd0;
            first_err_vld  <= 1'b0;
            first_err_idx  <= 4'd0;
            done           <= 1'b0;
            pass           <= 1'b0;
            idx_reg        <= 4'd0;
            settle_cnt_reg <= 4'd0;
            busy           <= 1'b1;
            state_reg      <= HOLD_STATE;
          end
        end

        ST_DRIVE: begin
          if (abort) begin
            // Partial error information is kept for inspection.
            state_reg      <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            idx_reg        <= 4'd0;
            settle_cnt_reg <= 4'd0;
          end else if (settle_cnt_reg == SETTLE_LAST) begin
            settle_cnt_reg <= 4'd0;
            state_reg      <= ST_CMP;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 4'd1;
          end
        end

        ST_CMP: begin
          if (abort) begin
            state_reg      <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            idx_reg        <= 4'd0;
            settle_cnt_reg <= 4'd0;
          end else begin
            if (mismatch) begin
              err_count <= err_next;
              mism      <= 1'b1;
              if (!first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_idx <= idx_reg;
              end
            end
            if (idx_reg == 4'd15) begin
              // Last vector: A..D stay at 1111 while the results are held.
              state_reg <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_next == 5'd0);
            end else begin
              idx_reg        <= idx_reg + 4'd1;
              settle_cnt_reg <= 4'd0;
              state_reg      <= HOLD_STATE;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed testbench for truth_table_checker.
// Instance a: EXPECT=16'h8001, SETTLE=2, Y from a selectable response model.
// Instance b: EXPECT=16'hA5C3, SETTLE=0, Y from a table that differs at vector 1.
`timescale 1ns/1ps
module tb_truth_table_checker;

  localparam logic [15:0] EXP_A = 16'h8001;
  localparam logic [15:0] EXP_B = 16'hA5C3;
  localparam logic [15:0] TT_B  = 16'hA5C1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0;

  logic a_a, b_a, c_a, d_a, y_a, busy_a, done_a, pass_a, fvld_a, mism_a;
  logic [4:0] err_a;
  logic [3:0] fidx_a;
  logic a_b, b_b, c_b, d_b, y_b, busy_b, done_b, pass_b, fvld_b, mism_b;
  logic [4:0] err_b;
  logic [3:0] fidx_b;

  logic [3:0] vec_a, vec_b;
  int y_mode = 3;
  int cur = 0;
  int checks = 0;
  int errors = 0;

  // Observation mux: cur selects which instance the checks look at.
  logic [3:0] o_vec, o_fidx;
  logic [4:0] o_err;
  logic o_busy, o_done, o_pass, o_fvld, o_mism;

  always #5 clk = ~clk;

  // Response table per mode: 0 -> Y=0, 1 -> Y=1, 2 -> A&B&C&D, other -> matches EXP_A.
  function automatic logic y_fun(input int sel, input int mode, input logic [3:0] v);
    logic [15:0] t;
    if (sel == 1) t = TT_B;
    else begin
      case (mode)
        0: t = 16'h0000;
        1: t = 16'hFFFF;
        2: t = 16'h8000;
        default: t = 16'h8001;
      endcase
    end
    return t[v];
  endfunction

  function automatic logic exp_bit(input int sel, input logic [3:0] v);
    logic [15:0] t;
    t = (sel == 1) ? EXP_B : EXP_A;
    return t[v];
  endfunction

  assign vec_a = {a_a, b_a, c_a, d_a};
  assign vec_b = {a_b, b_b, c_b, d_b};
  assign y_a   = (y_mode == 2) ? (a_a & b_a & c_a & d_a) : y_fun(0, y_mode, vec_a);
  assign y_b   = y_fun(1, 0, vec_b);

  assign o_vec  = (cur == 1) ? vec_b  : vec_a;
  assign o_fidx = (cur == 1) ? fidx_b : fidx_a;
  assign o_err  = (cur == 1) ? err_b  : err_a;
  assign o_busy = (cur == 1) ? busy_b : busy_a;
  assign o_done = (cur == 1) ? done_b : done_a;
  assign o_pass = (cur == 1) ? pass_b : pass_a;
  assign o_fvld = (cur == 1) ? fvld_b : fvld_a;
  assign o_mism = (cur == 1) ? mism_b : mism_a;

  truth_table_checker #(.EXPECT(EXP_A), .SETTLE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .A(a_a), .B(b_a), .C(c_a), .D(d_a), .Y(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_vld(fvld_a), .first_err_idx(fidx_a), .mism(mism_a)
  );

  truth_table_checker #(.EXPECT(EXP_B), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .A(a_b), .B(b_b), .C(c_b), .D(d_b), .Y(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_vld(fvld_b), .first_err_idx(fidx_b), .mism(mism_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 1) start_b = v;
    else start_a = v;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " vec"},  32'(o_vec),  0);
    chk({tag, " busy"}, 32'(o_busy), 0);
    chk({tag, " done"}, 32'(o_done), 0);
    chk({tag, " pass"}, 32'(o_pass), 0);
    chk({tag, " err"},  32'(o_err),  0);
    chk({tag, " fvld"}, 32'(o_fvld), 0);
    chk({tag, " fidx"}, 32'(o_fidx), 0);
    chk({tag, " mism"}, 32'(o_mism), 0);
  endtask

  // Full run from IDLE/DONE with per-cycle checks of the sweep, status and
  // running error count; optional start re-pulse after sample 'repulse'.
  task automatic run(input int s, input int mode, input int exp_err,
                     input logic exp_fvld, input logic [3:0] exp_fidx, input int repulse);
    int per, total, err_m;
    logic mm;
    string tg;
    per   = (s == 1) ? 1 : 3;
    total = 16 * per;
    err_m = 0;
    cur   = s;
    if (s == 0) y_mode = mode;
    set_start(s, 1'b1);
    step();
    set_start(s, 1'b0);
    for (int k = 0; k <= total; k++) begin
      mm = 1'b0;
      if (k > 0 && (k % per) == 0)
        mm = (y_fun(s, mode, 4'(k / per - 1)) != exp_bit(s, 4'(k / per - 1)));
      if (mm) err_m++;
      tg = $sformatf("run%0d m%0d k=%0d", s, mode, k);
      chk({tg, " vec"},  32'(o_vec),  (k < total) ? k / per : 15);
      chk({tg, " busy"}, 32'(o_busy), 32'(k < total));
      chk({tg, " done"}, 32'(o_done), 32'(k == total));
      chk({tg, " mism"}, 32'(o_mism), 32'(mm));
      chk({tg, " err"},  32'(o_err),  err_m);
      if (k == repulse) set_start(s, 1'b1);
      if (k < total) begin
        step();
        set_start(s, 1'b0);
      end
    end
    tg = $sformatf("end%0d m%0d", s, mode);
    chk({tg, " pass"}, 32'(o_pass), 32'(exp_err == 0));
    chk({tg, " err"},  32'(o_err),  exp_err);
    chk({tg, " fvld"}, 32'(o_fvld), 32'(exp_fvld));
    chk({tg, " fidx"}, 32'(o_fidx), 32'(exp_fidx));
  endtask

  initial begin
    // Reset values while rst_n is held low.
    #23;
    cur = 0;
    chk_reset("rst_a");
    cur = 1;
    chk_reset("rst_b");
    cur = 0;
    @(negedge clk) rst_n = 1'b1;
    step();

    // Matching response: pass, 48-cycle run, 3 cycles per vector.
    run(0, 3, 0, 1'b0, 4'd0, -1);
    // Y tied 1 against 16'h8001: 14 errors, first at vector 1.
    run(0, 1, 14, 1'b1, 4'd1, -1);
    // Y = A&B&C&D against 16'h8001: vector 0 fails only.
    run(0, 2, 1, 1'b1, 4'd0, -1);
    // start re-pulsed mid-run is ignored.
    run(0, 1, 14, 1'b1, 4'd1, 10);

    // abort in DONE is ignored.
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort_done done", 32'(done_a), 1);
    chk("abort_done vec",  32'(vec_a),  15);
    chk("abort_done err",  32'(err_a),  14);

    // start and abort together while not busy: start wins.
    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("both busy", 32'(busy_a), 1);
    chk("both vec",  32'(vec_a),  0);
    chk("both err",  32'(err_a),  0);
    chk("both done", 32'(done_a), 0);

    // abort at cycle 20: vectors 1..5 already failed.
    repeat (19) step();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort busy", 32'(busy_a), 0);
    chk("abort done", 32'(done_a), 0);
    chk("abort vec",  32'(vec_a),  0);
    chk("abort err",  32'(err_a),  5);
    chk("abort fvld", 32'(fvld_a), 1);
    chk("abort fidx", 32'(fidx_a), 1);
    chk("abort mism", 32'(mism_a), 0);
    repeat (3) step();
    chk("idle busy", 32'(busy_a), 0);
    chk("idle vec",  32'(vec_a),  0);
    chk("idle err",  32'(err_a),  5);

    // Asynchronous reset at cycle 20 of a run.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (20) step();
    chk("prerst busy", 32'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1;
    cur = 0;
    chk_reset("midrst");
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("postrst busy", 32'(busy_a), 0);
    run(0, 1, 14, 1'b1, 4'd1, -1);

    // SETTLE=0 instance: one vector per cycle, vector 1 mismatches.
    run(1, 0, 1, 1'b1, 4'd1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
